keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
// - Reader side of the board's scanned-matrix interface: drives a one-hot column scan
//   into a 4x4 keypad and reads back the row lines.
// - Debounces a single pressed key; reports its code with a one-clock valid pulse.
// - Feeds game/control logic (e.g. direction input for the dot-matrix display blocks).
// PARAMETERS
// - SCAN_DIV       default 2500  clocks per column dwell (>=2)
// - DEBOUNCE       default 4     consecutive identical frames needed to accept press/release (>=1)
// - REPEAT_FRAMES  default 50    frames between auto-repeat pulses (used only with KEYPAD_REPEAT_EN)
// PORTS
// - clock      in   1   system clock
// - reset      in   1   asynchronous, active-low reset
// - row_in     in   4   keypad row lines, active-high, asynchronous to clock
// - col_out    out  4   one-hot column drive
// - key_code   out  4   code of accepted key = col_index*4 + row_index
// - key_valid  out  1   one-clock pulse when a key press is accepted
// - key_held   out  1   high while accepted key remains pressed
// BEHAVIOUR
// - Reset (reset=0, async): col_out=4'b0001, key_code=0, key_valid=0, key_held=0,
//   divider=0, frame accumulator=0, debounce count=0, FSM=IDLE, sync flops=0.
// - row_in passes through a 2-flop synchronizer; all sampling uses the synchronized value.
// - Divider counts 0..SCAN_DIV-1. tick = (divider==SCAN_DIV-1). On tick the synchronized
//   rows are stored into accumulator slot [col_index*4 +: 4], then col_out rotates left
//   (4'b1000 wraps to 4'b0001).
// - Frame ends on the tick that samples column 3; frame snapshot = 16-bit accumulator.
// - Frame classification: NONE (all 0), ONE (exactly one bit set, code = bit index), MULTI (>=2 bits).
// - FSM, evaluated only at frame end:
//   IDLE:     ONE -> DEBOUNCE, cand=code, count=1 (if DEBOUNCE==1 go straight to accept).
//   DEBOUNCE: ONE with same cand -> count+1; on count==DEBOUNCE -> PRESSED, key_code=cand,
//             key_valid pulses one clock, key_held=1.
//             ONE with different code -> restart with new cand, count=1.
//             NONE or MULTI -> IDLE, count=0.
//   PRESSED:  same code -> stay, count=0. NONE -> RELEASE, count=1.
//             MULTI or different code -> stay (no new key accepted until release).
//   RELEASE:  NONE -> count+1; on count==DEBOUNCE -> IDLE, key_held=0.
//             any key present -> PRESSED, count=0 (bounce on release ignored).
// - key_valid is asserted in the clock after the accepting frame-end tick; never two
//   consecutive cycles. key_code stable from that cycle until the next acceptance.
// - Latency press->key_valid: 2 sync clocks + up to one partial frame + DEBOUNCE frames.
// - Counters saturate; no width wrap. Reset mid-frame discards partial accumulator.
// CONFIGURATION
// - KEYPAD_REPEAT_EN defined: in PRESSED, a frame counter increments per same-code frame;
//   when it reaches REPEAT_FRAMES, key_valid pulses again (same key_code) and counter clears.
//   Counter clears on entry to PRESSED and on leaving it.
// - Not defined: exactly one key_valid per accepted press; REPEAT_FRAMES unused.
// TESTING (SCAN_DIV=4, DEBOUNCE=3, frame=16 clocks)
// - Reset: hold reset=0 -> col_out=0001, key_valid=0, key_held=0, key_code=0; release ->
//   col_out steps 0001,0010,0100,1000,0001 every 4 clocks.
// - Clean press: assert row_in[1] only while col_out=0100 -> after 3 full frames key_valid
//   single pulse, key_code=9, key_held=1; release -> key_held=0 after 3 empty frames.
// - Bounce: key 9 pressed for 2 frames, empty 1 frame, pressed 3 frames -> exactly one
//   key_valid, key_code=9, at end of final 3rd frame.
// - Multi-key: rows for codes 0 and 15 both pressed 5 frames -> no key_valid, FSM IDLE.
// - Hold + second key: accept code 4, then add code 7 for 10 frames -> no new pulse,
//   key_code stays 4; with KEYPAD_REPEAT_EN, REPEAT_FRAMES=5 -> pulse every 5 frames, code 4.
// - Async reset mid-DEBOUNCE (after 2 frames of code 3) -> all outputs to reset values
//   immediately; post-reset needs 3 fresh frames before key_valid.

Source files
------------

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad-side signal bundle: column drive out, row lines in, and the decoded key report.
// master = scanner, slave = keypad/consumer side.
interface keypad_matrix_scanner_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row_in,
      output col_out,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output row_in,
      input  col_out,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: one-hot column scan, per-frame classification, single-key debounce.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_matrix_scanner #(
   parameter int SCAN_DIV      = 2500,
   parameter int DEBOUNCE      = 4,
   parameter int REPEAT_FRAMES = 50
) (
   input  logic clock,
   input  logic reset,
   keypad_matrix_scanner_if.master kp
);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W:0]   DEB_N    = (CNT_W+1)'(DEBOUNCE);
`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
   localparam logic [REP_W:0] REP_N = (REP_W+1)'(REPEAT_FRAMES);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } state_t;

   logic [3:0]       row_s1_q, row_s2_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       col_q, col_d;
   logic [15:0]      acc_q, acc_d;
   state_t           state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             held_q, held_d;
`ifdef KEYPAD_REPEAT_EN
   logic [REP_W-1:0] rep_q, rep_d;
   logic [REP_W:0]   rep_inc;
`endif

   logic        tick;
   logic        frame_end;
   logic [1:0]  col_idx;
   logic [4:0]  n_ones;
   logic [3:0]  hit_code;
   logic        is_none, is_one;
   logic [CNT_W:0] cnt_inc;
   logic        accept, release_done;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         row_s1_q <= '0;
         row_s2_q <= '0;
         div_q    <= '0;
         col_q    <= 4'b0001;
         acc_q    <= '0;
         state_q  <= ST_IDLE;
         cand_q   <= '0;
         cnt_q    <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         held_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q    <= '0;
`endif
      end else begin
         row_s1_q <= kp.row_in;
         row_s2_q <= row_s1_q;
         div_q    <= div_d;
         col_q    <= col_d;
         acc_q    <= acc_d;
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         held_q   <= held_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q    <= rep_d;
`endif
      end
   end

   always_comb begin
      col_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (col_q[i]) col_idx = 2'(i);
      end
   end

   // acc_d already holds the column-3 sample on the frame-end tick, so it is the snapshot.
   always_comb begin
      tick      = (div_q == DIV_LAST);
      frame_end = tick && col_q[3];
      div_d     = tick ? '0 : div_q + 1'b1;
      col_d     = tick ? {col_q[2:0], col_q[3]} : col_q;
      acc_d     = acc_q;
      if (tick) acc_d[{col_idx, 2'b00} +: 4] = row_s2_q;
   end

   always_comb begin
      n_ones   = '0;
      hit_code = '0;
      for (int i = 0; i < 16; i++) begin
         if (acc_d[i]) begin
            n_ones   = n_ones + 5'd1;
            hit_code = 4'(i);
         end
      end
      is_none = (n_ones == 5'd0);
      is_one  = (n_ones == 5'd1);
   end

   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      cnt_d        = cnt_q;
      code_d       = code_q;
      valid_d      = 1'b0;
      held_d       = held_q;
      accept       = 1'b0;
      release_done = 1'b0;
      cnt_inc      = {1'b0, cnt_q} + 1'b1;
`ifdef KEYPAD_REPEAT_EN
      rep_d        = rep_q;
      rep_inc      = {1'b0, rep_q} + 1'b1;
`endif
      if (frame_end) begin
         case (state_q)
            ST_IDLE: begin
               if (is_one) begin
                  cand_d = hit_code;
                  if (DEBOUNCE == 1) begin
                     accept = 1'b1;
                  end else begin
                     state_d = ST_DEBOUNCE;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (is_one && hit_code == cand_q) begin
                  if (cnt_inc >= DEB_N) accept = 1'b1;
                  else                  cnt_d  = cnt_inc[CNT_W-1:0];
               end else if (is_one) begin
                  cand_d = hit_code;
                  cnt_d  = CNT_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            ST_PRESSED: begin
               if (is_none) begin
                  if (DEBOUNCE == 1) begin
                     release_done = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                     cnt_d   = CNT_W'(1);
                  end
`ifdef KEYPAD_REPEAT_EN
                  rep_d = '0;
`endif
               end else begin
                  if (is_one && hit_code == code_q) cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                  // The held key still being seen counts, even alongside extra keys.
                  if (acc_d[code_q]) begin
                     if (rep_inc >= REP_N) begin
                        valid_d = 1'b1;
                        rep_d   = '0;
                     end else begin
                        rep_d = rep_inc[REP_W-1:0];
                     end
                  end
`endif
               end
            end
            ST_RELEASE: begin
               if (is_none) begin
                  if (cnt_inc >= DEB_N) release_done = 1'b1;
                  else                  cnt_d        = cnt_inc[CNT_W-1:0];
               end else begin
                  state_d = ST_PRESSED;
                  cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                  rep_d   = '0;
`endif
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (accept) begin
            state_d = ST_PRESSED;
            code_d  = hit_code;
            valid_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
         end
         if (release_done) begin
            state_d = ST_IDLE;
            held_d  = 1'b0;
            cnt_d   = '0;
         end
      end
   end

   assign kp.col_out   = col_q;
   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: directed frame table, async-reset sequence, random frames vs model.
module tb_keypad_matrix_scanner;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int REP      = 5;
   localparam int FRAME    = SCAN_DIV * 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] mask  = '0;
   logic [3:0]  row_drive;

   keypad_matrix_scanner_if kp();

   keypad_matrix_scanner #(
      .SCAN_DIV      (SCAN_DIV),
      .DEBOUNCE      (DEB),
      .REPEAT_FRAMES (REP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .kp    (kp)
   );

   always #5 clock = ~clock;

   // Keypad physics: a pressed key shorts its row to its column while that column is driven.
   always_comb begin
      row_drive = '0;
      for (int j = 0; j < 4; j++) begin
         if (kp.col_out[j]) row_drive = row_drive | mask[j*4 +: 4];
      end
   end
   assign kp.row_in = row_drive;

   typedef struct {
      logic [15:0] m;
      logic        v;
      logic        h;
      logic [3:0]  c;
   } vec_t;

   vec_t        tbl[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          frame_no = 0;
   logic        exp_held = 1'b0;
   logic [3:0]  exp_code = '0;

   // Reference model state: recent frame masks and the accepted-key view.
   logic [15:0] hist[$];
   logic        m_held = 1'b0;
   logic [3:0]  m_code = '0;
   logic [15:0] m_prev = '0;
   int          m_rep  = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s frame %0d: got %0h expected %0h", name, frame_no, act, exp);
      end
   endtask

   task automatic add_vec(input logic [15:0] m, input logic v, input logic h, input logic [3:0] c);
      vec_t e;
      e.m = m; e.v = v; e.h = h; e.c = c;
      tbl.push_back(e);
   endtask

   function automatic int one_code(input logic [15:0] m);
      if ($countones(m) != 1) return -1;
      for (int i = 0; i < 16; i++) if (m[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_held = 1'b0;
      m_code = '0;
      m_prev = '0;
      m_rep  = 0;
   endtask

   task automatic model_frame(input logic [15:0] m, output logic v, output logic h, output logic [3:0] c);
      bit was_pressed;
      bit same_one, all_none;
      int c0;
      was_pressed = m_held && (m_prev != 0);
      hist.push_back(m);
      if (hist.size() > DEB) void'(hist.pop_front());
      c0       = one_code(hist[0]);
      same_one = (hist.size() == DEB) && (c0 >= 0);
      all_none = (hist.size() == DEB);
      foreach (hist[k]) begin
         if (one_code(hist[k]) != c0) same_one = 0;
         if (hist[k] != 0)            all_none = 0;
      end
      v = 1'b0;
      if (!m_held) begin
         if (same_one) begin
            m_held = 1'b1;
            m_code = 4'(c0);
            m_rep  = 0;
            v      = 1'b1;
         end
      end else begin
`ifdef KEYPAD_REPEAT_EN
         if (was_pressed && m[m_code]) begin
            m_rep++;
            if (m_rep == REP) begin
               v     = 1'b1;
               m_rep = 0;
            end
         end else if (!was_pressed || m == 0) begin
            m_rep = 0;
         end
`endif
         if (all_none) m_held = 1'b0;
      end
      m_prev = m;
      h = m_held;
      c = m_code;
   endtask

   // Apply one frame's key set starting at a frame boundary and check every cycle of it.
   task automatic run_frame(input logic [15:0] m, input logic ev, input logic eh, input logic [3:0] ec);
      logic [3:0] exp_col;
      mask = m;
      for (int c = 1; c <= FRAME; c++) begin
         @(posedge clock);
         #1;
         exp_col = 4'b0001 << ((c / SCAN_DIV) % 4);
         check("col_out", 16'(kp.col_out), 16'(exp_col));
         if (c < FRAME) begin
            check("key_valid_idle", 16'(kp.key_valid), 16'(1'b0));
            check("key_held", 16'(kp.key_held), 16'(exp_held));
            check("key_code", 16'(kp.key_code), 16'(exp_code));
         end else begin
            check("key_valid", 16'(kp.key_valid), 16'(ev));
            check("key_held_end", 16'(kp.key_held), 16'(eh));
            check("key_code_end", 16'(kp.key_code), 16'(ec));
            exp_held = eh;
            exp_code = ec;
         end
      end
      $display("frame %0d mask=%h valid=%b held=%b code=%0d", frame_no, m,
               kp.key_valid, kp.key_held, kp.key_code);
      frame_no++;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_col"},   16'(kp.col_out),   16'h0001);
      check({name, "_valid"}, 16'(kp.key_valid), 16'h0000);
      check({name, "_held"},  16'(kp.key_held),  16'h0000);
      check({name, "_code"},  16'(kp.key_code),  16'h0000);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      mask  = '0;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset_hold");
      reset    = 1'b1;
      exp_held = 1'b0;
      exp_code = '0;
      model_reset();
   endtask

   initial begin
      logic        mv, mh;
      logic [3:0]  mc;
      logic [15:0] rm;
      int          kind, len;

      // Directed frame table (DEBOUNCE=3, 16 clocks per frame).
      for (int i = 0; i < 3; i++) add_vec(16'h0200, i == 2, i == 2, (i == 2) ? 4'd9 : 4'd0);
      add_vec(16'h0000, 1'b0, 1'b1, 4'd9);
      add_vec(16'h0000, 1'b0, 1'b1, 4'd9);
      add_vec(16'h0000, 1'b0, 1'b0, 4'd9);
      add_vec(16'h0200, 1'b0, 1'b0, 4'd9);
      add_vec(16'h0200, 1'b0, 1'b0, 4'd9);
      add_vec(16'h0000, 1'b0, 1'b0, 4'd9);
      add_vec(16'h0200, 1'b0, 1'b0, 4'd9);
      add_vec(16'h0200, 1'b0, 1'b0, 4'd9);
      add_vec(16'h0200, 1'b1, 1'b1, 4'd9);
      for (int i = 0; i < 3; i++) add_vec(16'h0000, 1'b0, i < 2, 4'd9);
      for (int i = 0; i < 5; i++) add_vec(16'h8001, 1'b0, 1'b0, 4'd9);
      for (int i = 0; i < 3; i++) add_vec(16'h0010, i == 2, i == 2, (i == 2) ? 4'd4 : 4'd9);
      for (int i = 0; i < 10; i++) begin
`ifdef KEYPAD_REPEAT_EN
         add_vec(16'h0090, (i % REP) == REP - 1, 1'b1, 4'd4);
`else
         add_vec(16'h0090, 1'b0, 1'b1, 4'd4);
`endif
      end
      for (int i = 0; i < 3; i++) add_vec(16'h0000, 1'b0, i < 2, 4'd4);

      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset_init");
      @(negedge clock);
      reset = 1'b1;

      foreach (tbl[i]) run_frame(tbl[i].m, tbl[i].v, tbl[i].h, tbl[i].c);

      // Async reset in the middle of debouncing code 3; key_code 4 must clear at once.
      run_frame(16'h0008, 1'b0, 1'b0, 4'd4);
      run_frame(16'h0008, 1'b0, 1'b0, 4'd4);
      repeat (6) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check_reset_outputs("reset_async");
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("reset_async_hold");
      reset    = 1'b1;
      exp_held = 1'b0;
      exp_code = '0;
      run_frame(16'h0008, 1'b0, 1'b0, 4'd0);
      run_frame(16'h0008, 1'b0, 1'b0, 4'd0);
      run_frame(16'h0008, 1'b1, 1'b1, 4'd3);
      for (int i = 0; i < 3; i++) run_frame(16'h0000, 1'b0, i < 2, 4'd3);

      // Random frame runs against the frame-level model.
      do_reset();
      for (int s = 0; s < 50; s++) begin
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, 5);
         if (kind < 4)      rm = '0;
         else if (kind < 8) rm = 16'h0001 << $urandom_range(0, 15);
         else               rm = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         for (int f = 0; f < len; f++) begin
            model_frame(rm, mv, mh, mc);
            run_frame(rm, mv, mh, mc);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
